// File: rtl/pmic_timer_pkg.sv
// Shared sizing helpers for the PMIC sequencing timer.
package pmic_timer_pkg;

    // Prescaler counter width: ceil(log2(prescale)), never less than one bit.
    function automatic int unsigned pre_width(input int unsigned prescale);
        int unsigned w;
        w = (prescale > 1) ? $clog2(prescale) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pmic_timer_pkg

// File: rtl/pmic_timer_prescaler.sv
// Divides enabled cycles by PRESCALE; o_tick_c marks the cycle pre wraps.
module timer_prescaler
    import pmic_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick_c
);

    localparam int unsigned PW   = pre_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    // Tick is combinational so the parent decrements on the same edge pre wraps.
    assign o_tick_c = i_enable && (r_pre == LAST);

    // Prescale counter: cleared by reset or load, advances on enabled cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (i_clear) begin
            r_pre <= '0;
        end else if (i_enable) begin
            r_pre <= (r_pre == LAST) ? '0 : r_pre + PW'(1);
        end
    end

endmodule : timer_prescaler

// File: rtl/pmic_timer.sv
// Loadable, enable-gated down-counting timer with sticky expiry flag.
module pmic_timer
    import pmic_timer_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              en,
    input  logic              load,
    output logic              timeOut
);

    logic [DATA_W-1:0] r_cnt;
    logic              r_armed;
    logic              r_timeout;
    logic              w_enable;
    logic              w_tick;

    // Counting only happens once armed and before expiry.
    assign w_enable = en && r_armed && (r_cnt != '0);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (load),
        .i_enable (w_enable),
        .o_tick_c (w_tick)
    );

    // Count/arm/expiry state: reset > load > prescaled decrement > hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_timeout <= 1'b0;
        end else if (load) begin
            r_cnt     <= data;
            r_armed   <= 1'b1;
            r_timeout <= (data == '0);
        end else if (w_tick) begin
            r_cnt <= r_cnt - DATA_W'(1);
            if (r_cnt == DATA_W'(1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeOut = r_timeout;

endmodule : pmic_timer

// File: tb/tb_pmic_timer.sv
// Directed bench for pmic_timer at PRESCALE=1 and PRESCALE=3.
`timescale 1ns/1ps
module tb_pmic_timer;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data;
    logic              en;
    logic              load;
    logic              to1;
    logic              to3;

    int n_checks;
    int n_errors;

    pmic_timer #(.DATA_W(DATA_W), .PRESCALE(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .en      (en),
        .load    (load),
        .timeOut (to1)
    );

    pmic_timer #(.DATA_W(DATA_W), .PRESCALE(3)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .en      (en),
        .load    (load),
        .timeOut (to3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        data  = 8'd3;
        en    = 1'b0;
        load  = 1'b0;

        // Reset dominates load/en toggling.
        for (int i = 0; i < 10; i++) begin
            load = i[0];
            en   = i[1];
            step();
            check("rst_to1", 32'(to1), 32'd0);
            check("rst_to3", 32'(to3), 32'd0);
        end
        reset = 1'b1; load = 1'b0; en = 1'b0;
        step();
        check("rst_cnt", 32'(dut1.r_cnt), 32'd0);
        check("rst_to_rel", 32'(to1), 32'd0);

        // Enable without any load: never expires.
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("noload_to", 32'(to1), 32'd0);
        end

        // Basic expiry: data=5 expires on 5th enabled edge, then sticky.
        en = 1'b0; load = 1'b1; data = 8'd5;
        step();
        check("basic_load", 32'(to1), 32'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("basic_cnt", 32'(to1), (i >= 5) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        step();
        check("basic_sticky", 32'(to1), 32'd1);

        // Pause/resume: 3 edges, long pause, then 5 more.
        load = 1'b1; data = 8'd8;
        step();
        check("pause_load", 32'(to1), 32'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_run1", 32'(to1), 32'd0);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_hold", 32'(to1), 32'd0);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("pause_run2", 32'(to1), (i == 5) ? 32'd1 : 32'd0);
        end

        // Reload priority: load+en together loads, no decrement.
        en = 1'b0; load = 1'b1; data = 8'd4;
        step();
        load = 1'b0; en = 1'b1;
        step();
        step();
        check("reload_mid", 32'(dut1.r_cnt), 32'd2);
        load = 1'b1; data = 8'd6;
        step();
        check("reload_to", 32'(to1), 32'd0);
        check("reload_cnt", 32'(dut1.r_cnt), 32'd6);
        load = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("reload_run", 32'(to1), (i >= 6) ? 32'd1 : 32'd0);
        end
        load = 1'b1; data = 8'd0;
        step();
        check("zero_load", 32'(to1), 32'd1);
        load = 1'b0;
        step();
        check("zero_hold", 32'(to1), 32'd1);
        check("zero_cnt", 32'(dut1.r_cnt), 32'd0);

        // PRESCALE=3: data=2 expires after 6 enabled edges.
        en = 1'b0; load = 1'b1; data = 8'd2;
        step();
        check("ps_load", 32'(to3), 32'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("ps_run", 32'(to3), (i >= 6) ? 32'd1 : 32'd0);
        end

        // Reset after 3 enabled edges disarms; no later expiry.
        en = 1'b0; load = 1'b1;
        step();
        check("ps2_load", 32'(to3), 32'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ps2_run", 32'(to3), 32'd0);
        end
        reset = 1'b0;
        step();
        check("ps2_rst_to", 32'(to3), 32'd0);
        check("ps2_rst_cnt", 32'(dut3.r_cnt), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("ps2_after", 32'(to3), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pmic_timer

// File: doc/pmic_timer.md
Name: pmic_timer

Overview:
- Loadable, enable-gated down-counting timer for the PMIC sequencing logic.
- A delay value is loaded from the `data` input (normally driven by the upstream delay-select mux).
- The count decrements while `en` is high, and `timeOut` asserts when the loaded delay has fully elapsed.
- `timeOut` is a sticky level, used to advance power-rail sequencing steps.

Parameters:
- DATA_W, 8, width of the `data` input and of the count register (>=1).
- PRESCALE, 1, number of enabled clock cycles per count decrement (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- data  input  DATA_W  delay value, sampled on a load.
- en  input  1  count enable, level-sensitive.
- load  input  1  load strobe, level-sensitive; every cycle it is high reloads the timer.
- timeOut  output  1  registered expiry flag, high when the loaded delay has elapsed.

Behaviour:
- Internal state:
  - `cnt` (DATA_W bits).
  - `pre` (prescaler, ceil(log2(PRESCALE)) bits, minimum 1 bit).
  - `armed` (1 bit).
  - `timeOut` (registered).
- Reset (reset==0 at a clock edge) takes priority over everything: cnt=0, pre=0, armed=0, timeOut=0.
- Load (reset==1, load==1) takes priority over en:
  - cnt<=data, pre<=0, armed<=1.
  - timeOut<=1 if data==0 (immediate expiry), else timeOut<=0.
- Count (reset==1, load==0, en==1, armed==1, cnt!=0):
  - If pre==PRESCALE-1: pre<=0 and cnt<=cnt-1; when cnt==1, timeOut<=1 on that same edge.
  - Otherwise: pre<=pre+1.
- Hold: with en==0 and load==0, all state holds. The timer pauses and resumes without loss.
- Not armed (after reset, no load yet): en is ignored and timeOut stays 0.
- Expired (cnt==0, armed==1): timeOut stays 1 and cnt stays 0, regardless of en. The state is cleared only by load or reset.
- Latency: with PRESCALE=1 and data=N>0, timeOut rises on the Nth rising edge with en==1 after the load edge. In general it rises after N*PRESCALE enabled edges.
- Wrap-around: no wrap is possible; cnt never decrements below 0.
- A reload mid-count restarts the timer with the new value and clears timeOut (unless data==0).
- Reset mid-count disarms the timer; timeOut falls on the reset edge.
- Simultaneous load and en: load wins, and no decrement occurs in that cycle.
- No combinational paths from inputs to timeOut.

Decomposition:
- No shared package needed.
- DATA_W and PRESCALE are module parameters; the top-level integration overrides them.
- One natural sub-module: `timer_prescaler`.
  - Inputs: clk, reset, clear (= load), enable (= en & armed & cnt!=0).
  - Output: a 1-cycle `tick` when pre wraps.
  - The parent decrements cnt on tick.

Test Plan:
- Reset: hold reset=0 for 10 cycles with load/en toggling -> timeOut=0 throughout, and cnt=0 after release.
- Basic expiry: PRESCALE=1, load data=5 for 1 cycle, then en=1 for 10 cycles -> timeOut rises on the 5th enabled edge and stays high after en drops.
- En without load: after reset, en=1 for 10 cycles -> timeOut stays 0.
- Pause/resume: load 8, en=1 for 3 cycles, en=0 for 10 cycles, en=1 for 5 cycles -> timeOut rises on the 5th edge of the second burst and never during the pause.
- Reload/priority: load 4, count 2, then assert load and en together with data=6 -> no decrement that cycle, timeOut=0, and expiry 6 enabled edges later. A load with data=0 -> timeOut=1 on the load edge.
- Prescale and reset mid-run: PRESCALE=3, load 2, en=1 -> timeOut rises after 6 enabled edges. Repeat and pull reset low after 3 enabled edges -> timeOut=0 and no later expiry without a reload.
